// File: rtl/serial_frame_decoder.sv
// -----------------------------------------------------------------------------
// serial_frame_decoder
//
// Assembles framed packets from the byte stream of the slave-side serial
// receiver. Frame layout on the wire:
//
//    HEADER | address | length | payload[0 .. length-1] | checksum
//
// The checksum is the modulo-256 sum of address, length and payload bytes.
// Payload bytes addressed to this node (or to broadcast 8'hFF) are written
// out as they arrive. The frame is then confirmed with frame_done or rejected
// with frame_err/err_code. Writes already issued for a frame that later fails
// are not retracted, so the consumer must commit only on frame_done.
//
// Ports
//    clk         in   system clock, rising edge
//    reset       in   asynchronous, active-low; clears all state
//    byte_in     in   received byte, sampled on the rising edge of byte_ready
//    byte_ready  in   level from the receiver; each 0->1 edge is one new byte
//    rx_timeout  in   level from the receiver; each 0->1 edge means line idle
//    wr_en       out  one-cycle payload write strobe
//    wr_addr     out  payload byte index (0-based), held when wr_en=0
//    wr_data     out  payload byte, held when wr_en=0
//    frame_done  out  one-cycle pulse: valid frame for this node
//    frame_len   out  payload length of the last good frame, held
//    frame_err   out  one-cycle pulse: frame rejected
//    err_code    out  01 bad length, 10 checksum, 11 timeout; held
// -----------------------------------------------------------------------------
module serial_frame_decoder #(
   parameter logic [7:0] DEV_ADDR = 8'h01,
   parameter logic [7:0] HEADER   = 8'hA5,
   parameter int         MAX_LEN  = 16,
   parameter int         AW       = $clog2(MAX_LEN),
   parameter int         LW       = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    byte_in,
   input  logic          byte_ready,
   input  logic          rx_timeout,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          frame_done,
   output logic [LW-1:0] frame_len,
   output logic          frame_err,
   output logic [1:0]    err_code
);

   typedef enum logic [2:0] {
      HUNT,
      ADDR,
      LEN,
      DATA,
      CHK
   } state_t;

   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHKSUM  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   state_t          state;
   logic            ready_d;
   logic            to_d;
   logic [7:0]      sum;
   logic [AW-1:0]   idx;
   logic [LW-1:0]   len;
   logic            addr_ok;

   logic            byte_stb;
   logic            to_stb;
   logic            len_ok;
   logic            last_payload;

   // Both receiver signals are levels; only their rising edges carry events.
   assign byte_stb = byte_ready & ~ready_d;
   assign to_stb   = rx_timeout & ~to_d;

   // Length byte is legal when 1..MAX_LEN; widened so MAX_LEN=255 still works.
   assign len_ok = (byte_in != 8'h00) && ({1'b0, byte_in} <= 9'(MAX_LEN));

   // Payload byte currently being received is the final one of the frame.
   assign last_payload = (LW'(idx) == (len - LW'(1)));

   // NOTE: all state and outputs are flops updated with non-blocking
   // assignments, so every branch below reads the pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HUNT;
         ready_d    <= 1'b0;
         to_d       <= 1'b0;
         sum        <= '0;
         idx        <= '0;
         len        <= '0;
         addr_ok    <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         frame_err  <= 1'b0;
         err_code   <= '0;
      end else begin
         ready_d <= byte_ready;
         to_d    <= rx_timeout;

         // NOTE: strobes default low every cycle so each one lasts exactly
         // one cycle; the held outputs (wr_addr, frame_len, ...) have no
         // default and keep their value.
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         // A timeout inside a frame wins over a coincident byte, which is
         // dropped. In HUNT the timeout is meaningless and bytes proceed.
         if (to_stb && (state != HUNT)) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= HUNT;
         end else if (byte_stb) begin
            unique case (state)
               HUNT: begin
                  if (byte_in == HEADER) begin
                     state <= ADDR;
                  end
               end

               ADDR: begin
                  addr_ok <= (byte_in == DEV_ADDR) || (byte_in == 8'hFF);
                  sum     <= byte_in;
                  state   <= LEN;
               end

               LEN: begin
                  if (!len_ok) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_LEN;
                     state     <= HUNT;
                  end else begin
                     len   <= LW'(byte_in);
                     idx   <= '0;
                     sum   <= sum + byte_in;
                     state <= DATA;
                  end
               end

               DATA: begin
                  // Frames for other nodes are still parsed to keep framing,
                  // but never reach the register file.
                  if (addr_ok) begin
                     wr_en   <= 1'b1;
                     wr_addr <= idx;
                     wr_data <= byte_in;
                  end
                  sum <= sum + byte_in;
                  idx <= idx + AW'(1);
                  if (last_payload) begin
                     state <= CHK;
                  end
               end

               CHK: begin
                  if (byte_in != sum) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CHKSUM;
                  end else if (addr_ok) begin
                     frame_done <= 1'b1;
                     frame_len  <= len;
                  end
                  state <= HUNT;
               end

               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_decoder
//
// Directed scenarios followed by randomized frames. Expected output events
// (writes, frame_done, frame_err) are derived at frame level from the frame
// contents and compared in order with the events observed on the outputs.
// -----------------------------------------------------------------------------
module tb_serial_frame_decoder;

   localparam int         MAX_LEN = 16;
   localparam int         AW      = $clog2(MAX_LEN);
   localparam int         LW      = $clog2(MAX_LEN + 1);
   localparam logic [7:0] DEV     = 8'h01;
   localparam logic [7:0] HDR     = 8'hA5;

   localparam logic [7:0] K_WR   = 8'h57;
   localparam logic [7:0] K_DONE = 8'h44;
   localparam logic [7:0] K_ERR  = 8'h45;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    byte_in;
   logic          byte_ready;
   logic          rx_timeout;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic [LW-1:0] frame_len;
   logic          frame_err;
   logic [1:0]    err_code;

   serial_frame_decoder #(
      .DEV_ADDR (DEV),
      .HEADER   (HDR),
      .MAX_LEN  (MAX_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_ready (byte_ready),
      .rx_timeout (rx_timeout),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .frame_err  (frame_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] act_q[$];
   int          last_len = 0;
   int          last_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ev(input logic [7:0] kind, input logic [7:0] a, input logic [7:0] b);
      return {kind, a, b, 8'h00};
   endfunction

   // Output monitor: one event per asserted strobe cycle.
   always @(negedge clk) begin
      if (reset) begin
         if (wr_en)      act_q.push_back(ev(K_WR, 8'(wr_addr), wr_data));
         if (frame_done) act_q.push_back(ev(K_DONE, 8'(frame_len), 8'h00));
         if (frame_err)  act_q.push_back(ev(K_ERR, 8'(err_code), 8'h00));
         if (frame_done || frame_err)
            check("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
      end
   end

   // ---------------- reference model (frame level) ----------------
   function automatic logic addr_match(input logic [7:0] a);
      return (a == DEV) || (a == 8'hFF);
   endfunction

   function automatic logic [7:0] frame_sum(input logic [7:0] addr, input bq_t p);
      int s = int'(addr) + p.size();
      foreach (p[i]) s += int'(p[i]);
      return 8'(s % 256);
   endfunction

   task automatic model_frame(input logic [7:0] addr, input bq_t p, input logic [7:0] chk);
      if (addr_match(addr))
         foreach (p[i]) exp_q.push_back(ev(K_WR, 8'(i), p[i]));
      if (chk != frame_sum(addr, p)) begin
         exp_q.push_back(ev(K_ERR, 8'd2, 8'h00));
         last_err = 2;
      end else if (addr_match(addr)) begin
         exp_q.push_back(ev(K_DONE, 8'(p.size()), 8'h00));
         last_len = p.size();
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      byte_in    = b;
      byte_ready = 1'b1;
      @(negedge clk);
      byte_ready = 1'b0;
   endtask

   task automatic send_byte_hold(input logic [7:0] b, input int n);
      @(negedge clk);
      byte_in    = b;
      byte_ready = 1'b1;
      repeat (n) @(negedge clk);
      byte_ready = 1'b0;
   endtask

   task automatic send_timeout();
      @(negedge clk);
      rx_timeout = 1'b1;
      @(negedge clk);
      rx_timeout = 1'b0;
   endtask

   task automatic send_byte_with_timeout(input logic [7:0] b);
      @(negedge clk);
      byte_in    = b;
      byte_ready = 1'b1;
      rx_timeout = 1'b1;
      @(negedge clk);
      byte_ready = 1'b0;
      rx_timeout = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] addr, input bq_t p, input bit corrupt);
      logic [7:0] chk;
      chk = frame_sum(addr, p);
      if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
      model_frame(addr, p, chk);
      send_byte(HDR);
      send_byte(addr);
      send_byte(8'(p.size()));
      foreach (p[i]) send_byte(p[i]);
      send_byte(chk);
   endtask

   task automatic flush(input string tag);
      int n;
      repeat (3) @(negedge clk);
      check({tag, "_event_count"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_event"}, act_q[i], exp_q[i]);
      check({tag, "_frame_len"}, 32'(frame_len), last_len);
      check({tag, "_err_code"}, 32'(err_code), last_err);
      act_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [7:0] pick_addr();
      logic [7:0] a;
      case ($urandom_range(0, 3))
         0, 1:    a = DEV;
         2:       a = 8'hFF;
         default: begin
            a = 8'($urandom_range(0, 255));
            if (addr_match(a)) a = 8'h07;
         end
      endcase
      return a;
   endfunction

   function automatic bq_t rand_payload(input int len);
      bq_t p;
      for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
      return p;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      bq_t        p;
      logic [7:0] a;
      logic [7:0] b;
      bq_t        bytes;
      int         len;
      int         k;

      reset      = 1'b0;
      byte_in    = 8'h00;
      byte_ready = 1'b0;
      rx_timeout = 1'b0;
      #2;
      check("reset_wr_en",      32'(wr_en),      32'd0);
      check("reset_wr_addr",    32'(wr_addr),    32'd0);
      check("reset_wr_data",    32'(wr_data),    32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      check("reset_frame_len",  32'(frame_len),  32'd0);
      check("reset_frame_err",  32'(frame_err),  32'd0);
      check("reset_err_code",   32'(err_code),   32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // 1: good frame, with output timing checked directly
      p = '{8'h11, 8'h22, 8'h33};
      model_frame(DEV, p, 8'h6A);
      send_byte(HDR);
      send_byte(DEV);
      send_byte(8'h03);
      foreach (p[i]) begin
         send_byte(p[i]);
         check("t1_wr_en",   32'(wr_en),   32'd1);
         check("t1_wr_addr", 32'(wr_addr), i);
         check("t1_wr_data", 32'(wr_data), 32'(p[i]));
      end
      send_byte(8'h6A);
      check("t1_frame_done", 32'(frame_done), 32'd1);
      check("t1_frame_err",  32'(frame_err),  32'd0);
      check("t1_frame_len",  32'(frame_len),  32'd3);
      check("t1_wr_addr_held", 32'(wr_addr), 32'd2);
      check("t1_wr_data_held", 32'(wr_data), 32'h33);
      flush("t1");

      // 2: same frame, bad checksum
      model_frame(DEV, p, 8'h6B);
      send_byte(HDR); send_byte(DEV); send_byte(8'h03);
      foreach (p[i]) send_byte(p[i]);
      send_byte(8'h6B);
      check("t2_frame_err", 32'(frame_err), 32'd1);
      check("t2_err_code",  32'(err_code),  32'd2);
      flush("t2");

      // 3: zero and oversize lengths, then a non-header byte in HUNT
      exp_q.push_back(ev(K_ERR, 8'd1, 8'h00));
      send_byte(HDR); send_byte(DEV); send_byte(8'h00);
      check("t3_zero_len_err", 32'(err_code), 32'd1);
      exp_q.push_back(ev(K_ERR, 8'd1, 8'h00));
      send_byte(HDR); send_byte(DEV); send_byte(8'(MAX_LEN + 1));
      check("t3_big_len_err", 32'(frame_err), 32'd1);
      last_err = 1;
      send_byte(DEV);
      send_frame(DEV, '{8'h01, 8'h02}, 1'b0);
      flush("t3");

      // 4: timeout mid-payload, then a one-byte frame
      exp_q.push_back(ev(K_WR, 8'd0, 8'h11));
      exp_q.push_back(ev(K_ERR, 8'd3, 8'h00));
      last_err = 3;
      send_byte(HDR); send_byte(DEV); send_byte(8'h02); send_byte(8'h11);
      send_timeout();
      send_frame(DEV, '{8'h44}, 1'b0);
      flush("t4");

      // 5: other node (silent), then broadcast
      model_frame(8'h07, '{8'h5A}, 8'h62);
      send_byte(HDR); send_byte(8'h07); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h62);
      model_frame(8'hFF, '{8'h5A}, 8'h5A);
      send_byte(HDR); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5A);
      flush("t5");

      // timeout coincident with a byte mid-frame, then coincident in HUNT
      exp_q.push_back(ev(K_ERR, 8'd3, 8'h00));
      last_err = 3;
      send_byte(HDR); send_byte(DEV); send_byte(8'h02);
      send_byte_with_timeout(8'h11);
      model_frame(DEV, '{8'h44}, 8'h46);
      send_byte_with_timeout(HDR);
      send_byte(DEV); send_byte(8'h01); send_byte(8'h44); send_byte(8'h46);
      flush("t_coincident");

      // maximum-length broadcast frame
      send_frame(8'hFF, rand_payload(MAX_LEN), 1'b0);
      flush("t_maxlen");

      // 6: junk, held byte_ready, async reset mid-DATA
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
      model_frame(DEV, '{8'h05, 8'h06}, 8'h0E);
      send_byte_hold(HDR, 10);
      send_byte(DEV); send_byte(8'h02); send_byte(8'h05); send_byte(8'h06); send_byte(8'h0E);
      flush("t6_held");
      exp_q.push_back(ev(K_WR, 8'd0, 8'h10));
      exp_q.push_back(ev(K_WR, 8'd1, 8'h20));
      send_byte(HDR); send_byte(DEV); send_byte(8'h04); send_byte(8'h10); send_byte(8'h20);
      flush("t6_pre_reset");
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_wr_en",      32'(wr_en),      32'd0);
      check("t6_rst_wr_addr",    32'(wr_addr),    32'd0);
      check("t6_rst_wr_data",    32'(wr_data),    32'd0);
      check("t6_rst_frame_done", 32'(frame_done), 32'd0);
      check("t6_rst_frame_len",  32'(frame_len),  32'd0);
      check("t6_rst_frame_err",  32'(frame_err),  32'd0);
      check("t6_rst_err_code",   32'(err_code),   32'd0);
      last_len = 0;
      last_err = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      send_byte(8'h30);
      send_frame(DEV, '{8'hDE, 8'hAD, 8'hBE}, 1'b0);
      flush("t6_after_reset");

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            send_byte(b);
         end
         if ($urandom_range(0, 4) == 0) send_timeout();
         a = pick_addr();
         case ($urandom_range(0, 9))
            0: begin
               b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
               exp_q.push_back(ev(K_ERR, 8'd1, 8'h00));
               last_err = 1;
               send_byte(HDR); send_byte(a); send_byte(b);
            end
            1, 2: begin
               len = $urandom_range(1, MAX_LEN);
               p = rand_payload(len);
               bytes = '{a, 8'(len)};
               foreach (p[i]) bytes.push_back(p[i]);
               k = $urandom_range(0, len + 2);
               if (addr_match(a))
                  for (int i = 0; i < len; i++)
                     if (2 + i < k) exp_q.push_back(ev(K_WR, 8'(i), p[i]));
               exp_q.push_back(ev(K_ERR, 8'd3, 8'h00));
               last_err = 3;
               send_byte(HDR);
               for (int i = 0; i < k; i++) send_byte(bytes[i]);
               if ($urandom_range(0, 1) == 0) send_timeout();
               else send_byte_with_timeout(8'($urandom_range(0, 255)));
            end
            default: begin
               send_frame(a, rand_payload($urandom_range(1, MAX_LEN)), ($urandom_range(0, 3) == 0));
            end
         endcase
         flush("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_frame_decoder.md
Name: serial_frame_decoder

Overview:
Consumes the byte stream produced by the slave-side serial receiver (byte value, level-style ready, level-style idle timeout) and assembles framed packets. Each frame is: header, address, length, payload, checksum. The block validates the frame, writes payload bytes out through a simple write port to a downstream register file, and reports completion or the error class. It sits directly downstream of the receiver in the slave design.

Parameters:
DEV_ADDR, 8'h01, this node's address; 8'hFF is always accepted as broadcast.
HEADER, 8'hA5, frame start byte.
MAX_LEN, 16, maximum payload length in bytes (2..255).
AW, $clog2(MAX_LEN), width of wr_addr.
LW, $clog2(MAX_LEN+1), width of frame_len.

Ports:
clk  in  1  system clock, all logic on its rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
byte_in  in  8  received byte; valid when byte_ready rises
byte_ready  in  1  level from receiver; a 0->1 transition marks one new byte
rx_timeout  in  1  level from receiver; a 0->1 transition means the line went idle
wr_en  out  1  one-cycle payload write strobe
wr_addr  out  AW  payload byte index, 0-based
wr_data  out  8  payload byte
frame_done  out  1  one-cycle pulse: valid frame for this node
frame_len  out  LW  payload length of the last good frame; held between frames
frame_err  out  1  one-cycle pulse: frame rejected
err_code  out  2  01 bad length, 10 checksum mismatch, 11 truncated by timeout; held until the next error

Behaviour:
- Reset (reset=0, async): state HUNT; all outputs 0; edge registers ready_d=0 and to_d=0; sum, idx, len and the addr_ok flag cleared. Reset mid-frame discards the partial frame and emits no pulse.
- Edge detect: byte_stb = byte_ready & ~ready_d; to_stb = rx_timeout & ~to_d.
  - byte_in is sampled in the byte_stb cycle.
  - A byte_ready level held high produces exactly one byte.
- Registered outputs: wr_en, frame_done and frame_err assert in the cycle after the strobe that causes them, for exactly one cycle.
  - wr_addr and wr_data hold their last value when wr_en=0.
- HUNT: on byte_stb with byte_in==HEADER, go to ADDR. Any other byte is ignored, with no error.
- ADDR: on byte_stb:
  - addr_ok = (byte_in==DEV_ADDR) | (byte_in==8'hFF).
  - sum = byte_in.
  - go to LEN.
- LEN: on byte_stb:
  - If byte_in==0 or byte_in>MAX_LEN: frame_err with err_code=01, go to HUNT.
  - Otherwise: len=byte_in, idx=0, sum+=byte_in (mod 256), go to DATA.
- DATA: on byte_stb:
  - If addr_ok, pulse wr_en with wr_addr=idx and wr_data=byte_in.
  - sum+=byte_in; idx++.
  - When idx==len-1 at the strobe, go to CHK.
- CHK: on byte_stb:
  - byte_in==sum and addr_ok: frame_done pulse, frame_len=len.
  - byte_in==sum and !addr_ok: silent drop, no pulse.
  - byte_in!=sum: frame_err with err_code=10, regardless of addr_ok.
  - Always return to HUNT.
- Checksum: 8-bit modulo-256 sum of the address, length and payload bytes. The header and checksum bytes are excluded.
- Timeout: to_stb in ADDR, LEN, DATA or CHK gives frame_err with err_code=11 and a return to HUNT. to_stb in HUNT has no effect.
- Simultaneous to_stb and byte_stb: timeout wins and the byte is discarded. In HUNT, the byte is processed normally.
- Writes already issued for a frame that later fails are not retracted. The consumer acts only on frame_done.
- frame_done and frame_err are never asserted in the same cycle.
- Minimum byte spacing is 2 cycles, since byte_ready must fall between bytes. The block needs no back-pressure.

Test Plan:
1. Good frame A5 01 03 11 22 33 6A -> wr_en pulses at (0,11),(1,22),(2,33); one frame_done; frame_len=3; frame_err stays 0.
2. Same frame with checksum 6B -> the 3 writes still occur; frame_err with err_code=10; no frame_done.
3. A5 01 00, then A5 01 11 (MAX_LEN=16) -> frame_err with err_code=01 after each length byte; the next byte is parsed in HUNT.
4. A5 01 02 11, then an rx_timeout rise -> frame_err with err_code=11. A following good frame A5 01 01 44 46 decodes, with frame_len=1.
5. A5 07 01 5A 62 -> no wr_en, no frame_done, no frame_err. Broadcast A5 FF 01 5A 5A -> write (0,5A) and frame_done.
6. Bytes 00 FF 3C before a header, byte_ready held high for 10 cycles, and reset pulled low mid-DATA -> junk ignored; held level counts once; all outputs 0 immediately on reset; the next frame decodes cleanly.
